multicycle_controller: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/aludec_mc.sv | 41 ++++
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS control unit:
//               FSM state type, opcode and funct field values, the internal
//               ALU-operation class and the 3-bit ALU control codes.
//               BNEEX is always present in the state type; it is only
//               reachable when the design is built with MC_BNE_EN.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // ------------------------------------------------------------------------
    // FSM states. Encodings 13..15 are never entered; the controller maps them
    // back to FETCH with all enables low.
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    // ------------------------------------------------------------------------
    // Opcode field values, instr[31:26]
    // ------------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ------------------------------------------------------------------------
    // R-type funct field values, instr[5:0]
    // ------------------------------------------------------------------------
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ------------------------------------------------------------------------
    // ALU operation class selected by the FSM. ALU_ADD is the all-zero
    // encoding so that states which do not use the ALU default to add.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    // ------------------------------------------------------------------------
    // ALU control codes driven to the datapath
    // ------------------------------------------------------------------------
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/aludec_mc.sv
`default_nettype none
// ============================================================================
// Module      : aludec_mc
// Description : Combinational ALU decoder. Maps the FSM's ALU operation class
//               plus the R-type funct field to the datapath's 3-bit ALU
//               control. Unknown funct codes and unused aluop encodings decode
//               to add so the output is always a defined value.
// Ports       : aluop_i      in  2  ALU operation class from the FSM
//               funct_i      in  6  R-type function field, instr[5:0]
//               alucontrol_o out 3  ALU control code
// Revision    : 1.0 - initial release
// ============================================================================
module aludec_mc
    import mips_ctrl_pkg::*;
(
    input  aluop_t      aluop_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alucontrol_o
);

    always_comb begin
        alucontrol_o = ALUC_ADD;
        case (aluop_i)
            ALU_ADD: alucontrol_o = ALUC_ADD;
            ALU_SUB: alucontrol_o = ALUC_SUB;
            ALU_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALUC_ADD;
                    FUNCT_SUB: alucontrol_o = ALUC_SUB;
                    FUNCT_AND: alucontrol_o = ALUC_AND;
                    FUNCT_OR:  alucontrol_o = ALUC_OR;
                    FUNCT_SLT: alucontrol_o = ALUC_SLT;
                    default:   alucontrol_o = ALUC_ADD;
                endcase
            end
            default: alucontrol_o = ALUC_ADD;
        endcase
    end

endmodule : aludec_mc
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control unit for the multicycle MIPS datapath. A Moore FSM
//               steps through fetch/decode/execute/memory/writeback and drives
//               every datapath control input; an ALU decoder converts the
//               FSM's ALU operation class and funct into alucontrol.
//               Optional feature: define MC_BNE_EN to add bne support
//               (opcode 000101 -> BNEEX, branch taken when zero is low).
//               Without it, opcode 000101 is handled as an unknown op.
// Ports       : clk        in  1  system clock, rising edge
//               reset      in  1  synchronous active-high reset
//               op         in  6  opcode, instr[31:26]
//               funct      in  6  funct field, instr[5:0]
//               zero       in  1  ALU zero flag
//               pcEn       out 1  PC enable = pcwrite | (branch & taken)
//               IorD       out 1  memory address select (0 pc, 1 aluout)
//               memwrite   out 1  data memory write strobe
//               IRwrite    out 1  instruction register enable
//               regdst     out 1  write register select (0 rt, 1 rd)
//               memtoreg   out 1  writeback select (0 aluout, 1 data)
//               regwrite   out 1  register file write enable
//               alusrcA    out 1  ALU A select (0 pc, 1 regA)
//               alusrcB    out 2  ALU B select (regB/4/signimm/signimm<<2)
//               pcsrc      out 2  next-PC select (aluresult/aluout/jump)
//               alucontrol out 3  ALU operation code
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcEn,
    output logic        IorD,
    output logic        memwrite,
    output logic        IRwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrcA,
    output logic [1:0]  alusrcB,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol
);

    state_t   state_q;
    state_t   state_d;

    logic     w_pcwrite;
    logic     w_branch;
    logic     w_branch_ne;   // branch polarity: taken on ~zero instead of zero
    aluop_t   w_aluop;

    // ------------------------------------------------------------------------
    // State register: the only storage in the controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. op is stable for the whole instruction because it
    // comes from the instruction register, which only loads in FETCH.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:    state_d = MEMADR;
                    OP_RTYPE: state_d = RTYPEEX;
                    OP_BEQ:   state_d = BEQEX;
                    OP_ADDI:  state_d = ADDIEX;
                    OP_J:     state_d = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:   state_d = BNEEX;
`endif
                    // Unknown opcodes retire as a NOP
                    default:  state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
`ifdef MC_BNE_EN
            BNEEX:   state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic. Every control defaults low; each state raises only what
    // it uses. While reset is asserted the mux selects show the FETCH
    // settings and every enable is held low, regardless of the current state.
    // ------------------------------------------------------------------------
    always_comb begin
        IorD        = 1'b0;
        memwrite    = 1'b0;
        IRwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrcA     = 1'b0;
        alusrcB     = 2'b00;
        pcsrc       = 2'b00;
        w_pcwrite   = 1'b0;
        w_branch    = 1'b0;
        w_branch_ne = 1'b0;
        w_aluop     = ALU_ADD;

        case (state_q)
            FETCH: begin
                IRwrite   = 1'b1;
                alusrcB   = 2'b01;
                w_pcwrite = 1'b1;
            end
            DECODE: begin
                // Precompute the branch target into aluout
                alusrcB   = 2'b11;
            end
            MEMADR: begin
                alusrcA   = 1'b1;
                alusrcB   = 2'b10;
            end
            MEMRD: begin
                IorD      = 1'b1;
            end
            MEMWB: begin
                memtoreg  = 1'b1;
                regwrite  = 1'b1;
            end
            MEMWR: begin
                IorD      = 1'b1;
                memwrite  = 1'b1;
            end
            RTYPEEX: begin
                alusrcA   = 1'b1;
                w_aluop   = ALU_FUNCT;
            end
            RTYPEWB: begin
                regdst    = 1'b1;
                regwrite  = 1'b1;
            end
            BEQEX: begin
                alusrcA   = 1'b1;
                w_aluop   = ALU_SUB;
                pcsrc     = 2'b01;
                w_branch  = 1'b1;
            end
            ADDIEX: begin
                alusrcA   = 1'b1;
                alusrcB   = 2'b10;
            end
            ADDIWB: begin
                regwrite  = 1'b1;
            end
            JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                alusrcA     = 1'b1;
                w_aluop     = ALU_SUB;
                pcsrc       = 2'b01;
                w_branch    = 1'b1;
                w_branch_ne = 1'b1;
            end
`endif
            default: begin
                // Unreachable encodings: keep all defaults (NOP)
            end
        endcase

        pcEn = w_pcwrite | (w_branch & (zero ^ w_branch_ne));

        if (reset) begin
            pcEn      = 1'b0;
            IRwrite   = 1'b0;
            memwrite  = 1'b0;
            regwrite  = 1'b0;
            IorD      = 1'b0;
            alusrcA   = 1'b0;
            alusrcB   = 2'b01;
            pcsrc     = 2'b00;
            regdst    = 1'b0;
            memtoreg  = 1'b0;
            w_aluop   = ALU_ADD;
        end
    end

    // ------------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------------
    aludec_mc u_aludec (
        .aluop_i      (w_aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Instructions
//               are described as sequences of abstract phases; each phase
//               yields the full expected control word. A vector table covers
//               each instruction class, hand sequences cover reset, and a
//               random instruction stream exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
    logic [1:0]  alusrcB, pcsrc;
    logic [2:0]  alucontrol;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcEn       (pcEn),
        .IorD       (IorD),
        .memwrite   (memwrite),
        .IRwrite    (IRwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrcA    (alusrcA),
        .alusrcB    (alusrcB),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcEn;
        logic       IorD;
        logic       memwrite;
        logic       IRwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrcA;
        logic [1:0] alusrcB;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    ctrl_t act_w;
    assign act_w = {pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
                    alusrcA, alusrcB, pcsrc, alucontrol};

    // Abstract instruction phases
    typedef enum logic [3:0] {
        PH_NONE, PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW, PH_RE, PH_RW,
        PH_BE, PH_BN, PH_AE, PH_AW, PH_J
    } ph_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Phase k (0-based) of the instruction with opcode o
    function automatic ph_t phase_of(input logic [5:0] o, input int k);
        if (k == 0) return PH_F;
        if (k == 1) return PH_D;
        case (o)
            6'b100011: return (k == 2) ? PH_MA : (k == 3) ? PH_MR : (k == 4) ? PH_MWB : PH_NONE;
            6'b101011: return (k == 2) ? PH_MA : (k == 3) ? PH_MW : PH_NONE;
            6'b000000: return (k == 2) ? PH_RE : (k == 3) ? PH_RW : PH_NONE;
            6'b000100: return (k == 2) ? PH_BE : PH_NONE;
            6'b001000: return (k == 2) ? PH_AE : (k == 3) ? PH_AW : PH_NONE;
            6'b000010: return (k == 2) ? PH_J  : PH_NONE;
`ifdef MC_BNE_EN
            6'b000101: return (k == 2) ? PH_BN : PH_NONE;
`endif
            default:   return PH_NONE;
        endcase
    endfunction

    function automatic int n_cycles(input logic [5:0] o);
        int n = 0;
        while (phase_of(o, n) != PH_NONE) n++;
        return n;
    endfunction

    function automatic ctrl_t expect_ctrl(input ph_t p, input logic [5:0] f, input logic z);
        ctrl_t c = '0;
        c.alucontrol = 3'b010;
        case (p)
            PH_F:   begin c.IRwrite = 1; c.alusrcB = 2'b01; c.pcEn = 1; end
            PH_D:   begin c.alusrcB = 2'b11; end
            PH_MA:  begin c.alusrcA = 1; c.alusrcB = 2'b10; end
            PH_MR:  begin c.IorD = 1; end
            PH_MWB: begin c.memtoreg = 1; c.regwrite = 1; end
            PH_MW:  begin c.IorD = 1; c.memwrite = 1; end
            PH_RE:  begin c.alusrcA = 1; c.alucontrol = alu_of_funct(f); end
            PH_RW:  begin c.regdst = 1; c.regwrite = 1; end
            PH_BE:  begin c.alusrcA = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcEn = z; end
            PH_BN:  begin c.alusrcA = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcEn = ~z; end
            PH_AE:  begin c.alusrcA = 1; c.alusrcB = 2'b10; end
            PH_AW:  begin c.regwrite = 1; end
            PH_J:   begin c.pcsrc = 2'b10; c.pcEn = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Outputs expected while reset is held: FETCH selects, all enables low
    function automatic ctrl_t reset_ctrl();
        ctrl_t c = '0;
        c.alusrcB    = 2'b01;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 of the
    // next FETCH. Cycles are counted until IRwrite comes back (bounded).
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, output int cycles, output ctrl_t exec_c);
        int k = 0;
        ph_t p;
        op = o; funct = f; zero = z;
        exec_c = '0;
        do begin
            #1;
            if (k == 2) exec_c = act_w;
            p = phase_of(o, k);
            if (p != PH_NONE) check(tag, {17'd0, act_w}, {17'd0, expect_ctrl(p, f, z)});
            @(posedge clk); #1;
            k++;
        end while (!IRwrite && k < 8);
        if (k == 2) exec_c = act_w;
        cycles = k;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        logic [2:0] exec_alu;
        logic       exec_pcen;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int    cyc;
        ctrl_t ex;
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {17'd0, act_w}, {17'd0, reset_ctrl()});
        reset = 1'b0;

        // ---------------- vector table ----------------
        vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, 3'b010, 1'b0}); // lw
        vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, 3'b010, 1'b0}); // sw
        vecs.push_back('{6'b000000, 6'b101010, 1'b0, 4, 3'b111, 1'b0}); // slt
        vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, 3'b001, 1'b0}); // or
        vecs.push_back('{6'b000000, 6'b111111, 1'b0, 4, 3'b010, 1'b0}); // bad funct
        vecs.push_back('{6'b000000, 6'b100010, 1'b1, 4, 3'b110, 1'b0}); // sub
        vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, 3'b000, 1'b0}); // and
        vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, 3'b010, 1'b0}); // add
        vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, 3'b110, 1'b1}); // beq taken
        vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, 3'b110, 1'b0}); // beq not
        vecs.push_back('{6'b001000, 6'b000000, 1'b0, 4, 3'b010, 1'b0}); // addi
        vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, 3'b010, 1'b1}); // j
        vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, 3'b010, 1'b1}); // unknown
`ifdef MC_BNE_EN
        vecs.push_back('{6'b000101, 6'b000000, 1'b0, 3, 3'b110, 1'b1}); // bne taken
        vecs.push_back('{6'b000101, 6'b000000, 1'b1, 3, 3'b110, 1'b0}); // bne not
`else
        vecs.push_back('{6'b000101, 6'b000000, 1'b0, 2, 3'b010, 1'b1}); // bne = nop
`endif
        foreach (vecs[i]) begin
            run_instr("vec_step", vecs[i].op, vecs[i].funct, vecs[i].zero, cyc, ex);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cycles);
            check($sformatf("vec%0d_exec_alu", i), {29'd0, ex.alucontrol}, {29'd0, vecs[i].exec_alu});
            check($sformatf("vec%0d_exec_pcen", i), {31'd0, ex.pcEn}, {31'd0, vecs[i].exec_pcen});
        end

        // ---------------- reset in the middle of lw (MEMRD) ----------------
        op = 6'b100011; funct = 6'd0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_pre_IorD", {31'd0, IorD}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_cycle0", {17'd0, act_w}, {17'd0, reset_ctrl()});
        @(posedge clk); #1;
        check("midreset_cycle1", {17'd0, act_w}, {17'd0, reset_ctrl()});
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("post_reset_step", 6'b000010, 6'd0, 1'b0, cyc, ex);
        check("post_reset_cycles", cyc, 3);

        // ---------------- random instruction stream ----------------
        for (int n = 0; n < 300; n++) begin
            logic [5:0] ro, rf;
            logic       rz;
            case ($urandom_range(0, 7))
                0: ro = 6'b100011;
                1: ro = 6'b101011;
                2: ro = 6'b000000;
                3: ro = 6'b000100;
                4: ro = 6'b000101;
                5: ro = 6'b001000;
                6: ro = 6'b000010;
                default: ro = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rf = 6'b100000;
                1: rf = 6'b100010;
                2: rf = 6'b100100;
                3: rf = 6'b100101;
                4: rf = 6'b101010;
                default: rf = 6'($urandom);
            endcase
            rz = 1'($urandom);
            run_instr("rand_step", ro, rf, rz, cyc, ex);
            check("rand_cycles", cyc, n_cycles(ro));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multicycle_controller
`default_nettype wire
